// File: rtl/crc16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc16_pkg
//  Description : Shared types and constants for the serial CRC-16 controller:
//                controller state encoding, CRC/counter widths and the
//                default generator polynomial and preset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc16_pkg;

  // CRC register width and width of the processed-bit counter (covers 0..40).
  localparam int c_CRC_W = 16;
  localparam int c_CNT_W = 6;

  // Default generator polynomial (x^16 implicit) and LFSR preset.
  localparam logic [c_CRC_W-1:0] c_DEFAULT_POLY = 16'h1021;
  localparam logic [c_CRC_W-1:0] c_DEFAULT_INIT = 16'h0000;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : crc16_pkg
`default_nettype wire

// File: rtl/crc16_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc16_serial_ctrl_if
//  Description : Request/result bundle between the stimulus source (master)
//                and the serial CRC-16 controller (slave).
//                master drives : start, data_in, check_en, crc_ref
//                master samples: busy, done, crc_out, crc_ok, bit_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc16_serial_ctrl_if
  import crc16_pkg::*;
#(
  parameter int MSG_W = 34
) ();

  logic               start;
  logic [MSG_W-1:0]   data_in;
  logic               check_en;
  logic [c_CRC_W-1:0] crc_ref;
  logic               busy;
  logic               done;
  logic [c_CRC_W-1:0] crc_out;
  logic               crc_ok;
  logic [c_CNT_W-1:0] bit_cnt;

  modport master (
    output start, data_in, check_en, crc_ref,
    input  busy, done, crc_out, crc_ok, bit_cnt
  );

  modport slave (
    input  start, data_in, check_en, crc_ref,
    output busy, done, crc_out, crc_ok, bit_cnt
  );

endinterface : crc16_serial_ctrl_if
`default_nettype wire

// File: rtl/crc16_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : crc16_lfsr_step
//  Description : Combinational single-bit step of an MSB-first CRC-16 LFSR.
//                Ports: i_lfsr  - current LFSR value
//                       i_bit   - next message bit (MSB-first)
//                       i_poly  - generator polynomial, x^16 implicit
//                       o_lfsr  - LFSR value after consuming i_bit
//  Revision    : 1.0 - initial release
// ============================================================================
module crc16_lfsr_step
  import crc16_pkg::*;
(
  input  wire logic [c_CRC_W-1:0] i_lfsr,
  input  wire logic               i_bit,
  input  wire logic [c_CRC_W-1:0] i_poly,
  output logic      [c_CRC_W-1:0] o_lfsr
);

  logic w_fb;

  // Feedback is the bit leaving the register combined with the incoming bit.
  assign w_fb   = i_lfsr[c_CRC_W-1] ^ i_bit;
  assign o_lfsr = {i_lfsr[c_CRC_W-2:0], 1'b0} ^ (w_fb ? i_poly : '0);

endmodule : crc16_lfsr_step
`default_nettype wire

// File: rtl/crc16_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : crc16_serial_ctrl
//  Description : Sequencing controller for a bit-serial CRC-16. On an
//                accepted start the message is zero-extended to FRAME_W bits
//                and shifted MSB-first through the LFSR, one bit per clock.
//                The result is registered as the controller enters DONE, so
//                crc_out/crc_ok are valid together with the one-cycle done.
//                Ports: clk, reset (sync, active-high), bus (slave side of
//                crc16_serial_ctrl_if: start/data_in/check_en/crc_ref in,
//                busy/done/crc_out/crc_ok/bit_cnt out).
//  Revision    : 1.0 - initial release
// ============================================================================
module crc16_serial_ctrl
  import crc16_pkg::*;
#(
  parameter int                   MSG_W   = 34,
  parameter int                   FRAME_W = 40,
  parameter logic [c_CRC_W-1:0]   POLY    = c_DEFAULT_POLY,
  parameter logic [c_CRC_W-1:0]   INIT    = c_DEFAULT_INIT
) (
  input  wire logic          clk,
  input  wire logic          reset,
  crc16_serial_ctrl_if.slave bus
);

  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(FRAME_W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(FRAME_W);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_shift;
  logic               w_last;

  logic [FRAME_W-1:0] r_frame;
  logic [c_CRC_W-1:0] r_lfsr;
  logic [c_CRC_W-1:0] w_lfsr_next;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic               r_check_en;
  logic [c_CRC_W-1:0] r_crc_ref;
  logic [c_CRC_W-1:0] r_crc_out;
  logic               r_crc_ok;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == c_LAST_BIT) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // LFSR step for the current frame MSB
  // --------------------------------------------------------------------------
  crc16_lfsr_step u_step (
    .i_lfsr (r_lfsr),
    .i_bit  (r_frame[FRAME_W-1]),
    .i_poly (POLY),
    .o_lfsr (w_lfsr_next)
  );

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame    <= '0;
      r_lfsr     <= '0;
      r_bit_cnt  <= '0;
      r_check_en <= 1'b0;
      r_crc_ref  <= '0;
      r_crc_out  <= '0;
      r_crc_ok   <= 1'b0;
    end else if (w_load) begin
      r_frame    <= {{(FRAME_W-MSG_W){1'b0}}, bus.data_in};
      r_lfsr     <= INIT;
      r_bit_cnt  <= '0;
      r_check_en <= bus.check_en;
      r_crc_ref  <= bus.crc_ref;
    end else if (w_shift) begin
      r_frame <= r_frame << 1;
      r_lfsr  <= w_lfsr_next;
      // Saturating count keeps the debug view stable after the last bit.
      if (r_bit_cnt != c_CNT_MAX) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      // Capture the final value on the edge that enters DONE so the result
      // lines up with the done pulse.
      if (w_last) begin
        r_crc_out <= w_lfsr_next;
        r_crc_ok  <= r_check_en ? (w_lfsr_next == r_crc_ref) : 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == DONE);
  assign bus.crc_out = r_crc_out;
  assign bus.crc_ok  = r_crc_ok;
  assign bus.bit_cnt = r_bit_cnt;

endmodule : crc16_serial_ctrl
`default_nettype wire

// File: tb/tb_crc16_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc16_serial_ctrl
//  Description : Directed self-checking bench for crc16_serial_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc16_serial_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   cyc;

  crc16_serial_ctrl_if #(.MSG_W(34)) bus ();

  crc16_serial_ctrl #(
    .MSG_W   (34),
    .FRAME_W (40),
    .POLY    (16'h1021),
    .INIT    (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: shift {6'd0, d} MSB-first through CRC-16/0x1021.
  function automatic logic [15:0] crc_model(input logic [33:0] d);
    logic [39:0] f;
    logic [15:0] c;
    logic        fb;
    f = {6'd0, d};
    c = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      fb = c[15] ^ f[39];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      f  = f << 1;
    end
    return c;
  endfunction

  // Issue one start and follow the frame until busy drops (bounded).
  task automatic do_frame(input logic [33:0] d, input logic ce, input logic [15:0] r,
                          output int lat, output int bcnt, output int dcnt,
                          output logic [15:0] crc, output logic ok);
    lat = 0; bcnt = 0; dcnt = 0; crc = 16'hxxxx; ok = 1'bx;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = d; bus.check_en = ce; bus.crc_ref = r;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        dcnt++; lat = i; crc = bus.crc_out; ok = bus.crc_ok;
      end
      if (!bus.busy) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_vec++; if (bus.crc_out !== 16'h0000) begin n_err++; $display("FAIL reset_crc got %h want 0000", bus.crc_out); end
    n_vec++; if (bus.crc_ok !== 1'b0) begin n_err++; $display("FAIL reset_ok got %b want 0", bus.crc_ok); end
    n_vec++; if (bus.bit_cnt !== 6'd0) begin n_err++; $display("FAIL reset_bitcnt got %0d want 0", bus.bit_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_zero;
    int lat, bcnt, dcnt; logic [15:0] crc; logic ok;
    do_frame(34'h0, 1'b0, 16'h0, lat, bcnt, dcnt, crc, ok);
    n_vec++; if (lat !== 41) begin n_err++; $display("FAIL zero_latency got %0d want 41", lat); end
    n_vec++; if (bcnt !== 41) begin n_err++; $display("FAIL zero_busy_cycles got %0d want 41", bcnt); end
    n_vec++; if (dcnt !== 1) begin n_err++; $display("FAIL zero_done_count got %0d want 1", dcnt); end
    n_vec++; if (crc !== 16'h0000) begin n_err++; $display("FAIL zero_crc got %h want 0000", crc); end
    n_vec++; if (bus.bit_cnt !== 6'd40) begin n_err++; $display("FAIL zero_bitcnt_sat got %0d want 40", bus.bit_cnt); end
  endtask

  task automatic test_poly;
    logic [33:0] dv [3];
    logic [15:0] ev [3];
    int lat, bcnt, dcnt; logic [15:0] crc; logic ok;
    dv[0] = 34'h1;         ev[0] = 16'h1021;
    dv[1] = 34'h2;         ev[1] = 16'h2042;
    dv[2] = 34'h3FFFFFFFF; ev[2] = crc_model(34'h3FFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      do_frame(dv[i], 1'b0, 16'h0, lat, bcnt, dcnt, crc, ok);
      n_vec++;
      if (crc !== ev[i] || dcnt !== 1) begin
        n_err++; $display("FAIL poly_crc[%0d] got %h (dones %0d) want %h", i, crc, dcnt, ev[i]);
      end
    end
  endtask

  task automatic test_check;
    logic       cev [3];
    logic [15:0] rv [3];
    logic       okv [3];
    int lat, bcnt, dcnt; logic [15:0] crc; logic ok;
    cev[0] = 1'b1; rv[0] = 16'h1021; okv[0] = 1'b1;
    cev[1] = 1'b1; rv[1] = 16'h1022; okv[1] = 1'b0;
    cev[2] = 1'b0; rv[2] = 16'h1022; okv[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_frame(34'h1, cev[i], rv[i], lat, bcnt, dcnt, crc, ok);
      n_vec++;
      if (ok !== okv[i]) begin
        n_err++; $display("FAIL check_ok[%0d] got %b want %b", i, ok, okv[i]);
      end
    end
    // crc_ok holds after the done pulse.
    @(negedge clk);
    n_vec++; if (bus.crc_ok !== 1'b1) begin n_err++; $display("FAIL check_ok_hold got %b want 1", bus.crc_ok); end
  endtask

  task automatic test_ignore_start;
    int dcnt; logic [15:0] crc;
    dcnt = 0; crc = 16'hxxxx;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = 34'h1; bus.check_en = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 10) begin bus.start = 1'b1; bus.data_in = 34'h2; bus.crc_ref = 16'hFFFF; end
      if (i == 11) bus.start = 1'b0;
      if (bus.done) begin dcnt++; crc = bus.crc_out; end
      if (!bus.busy && i > 11) break;
    end
    n_vec++; if (crc !== 16'h1021) begin n_err++; $display("FAIL ignore_crc got %h want 1021", crc); end
    n_vec++; if (dcnt !== 1) begin n_err++; $display("FAIL ignore_done_count got %0d want 1", dcnt); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dcnt, stray; logic [15:0] crc; logic ok;
    stray = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = 34'h1; bus.check_en = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.crc_out !== 16'h0000) begin n_err++; $display("FAIL midrst_crc got %h want 0000", bus.crc_out); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", bus.done); end
    n_vec++; if (bus.bit_cnt !== 6'd0) begin n_err++; $display("FAIL midrst_bitcnt got %0d want 0", bus.bit_cnt); end
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray++;
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL midrst_stray_activity got %0d want 0", stray); end
    do_frame(34'h2, 1'b0, 16'h0, lat, bcnt, dcnt, crc, ok);
    n_vec++; if (crc !== 16'h2042) begin n_err++; $display("FAIL midrst_after_crc got %h want 2042", crc); end
  endtask

  task automatic test_back_to_back;
    int t [3];
    logic [15:0] c [3];
    int nd;
    nd = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = 34'h2; bus.check_en = 1'b0;
    for (int i = 0; i < 200 && nd < 3; i++) begin
      @(negedge clk);
      if (bus.done) begin t[nd] = cyc; c[nd] = bus.crc_out; nd++; end
    end
    bus.start = 1'b0;
    for (int i = 0; i < 60 && bus.busy; i++) @(negedge clk);
    n_vec++; if (nd !== 3) begin n_err++; $display("FAIL b2b_done_count got %0d want 3", nd); end
    if (nd == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (c[i] !== 16'h2042) begin n_err++; $display("FAIL b2b_crc[%0d] got %h want 2042", i, c[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (t[i] - t[i-1] !== 42) begin n_err++; $display("FAIL b2b_period[%0d] got %0d want 42", i, t[i] - t[i-1]); end
      end
    end
  endtask

  task automatic test_random;
    logic [33:0] d;
    int lat, bcnt, dcnt; logic [15:0] crc; logic ok;
    for (int i = 0; i < 4; i++) begin
      d = {2'($urandom), 32'($urandom)};
      do_frame(d, 1'b1, crc_model(d), lat, bcnt, dcnt, crc, ok);
      n_vec++;
      if (crc !== crc_model(d) || ok !== 1'b1) begin
        n_err++; $display("FAIL random_crc[%0d] data %h got %h/%b want %h/1", i, d, crc, ok, crc_model(d));
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.data_in = '0; bus.check_en = 1'b0; bus.crc_ref = '0;
    test_reset;
    test_zero;
    test_poly;
    test_check;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_crc16_serial_ctrl
`default_nettype wire
